// File: rtl/acumulador_bcd_pkg.sv
// Shared types and constant helpers for the BCD accumulator slice.
//   state_t    : sequencer states (IDLE, SUM, CONV, DONE)
//   clog2      : ceiling log2, usable in parameter expressions
//   bcd_digits : decimal digits needed to hold 2^sw - 1
//   add3       : double-dabble nibble correction (add 3 when >= 5)
package acumulador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    CONV,
    DONE
  } state_t;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (longint unsigned x = 1; x < longint'(v); x = x << 1) r++;
    return r;
  endfunction

  function automatic int bcd_digits(input int sw);
    int d;
    d = 0;
    for (longint unsigned v = (64'd1 << sw) - 64'd1; v != 0; v = v / 64'd10) d++;
    return (d == 0) ? 1 : d;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/acumulador_bcd_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   go       : held high while the operand is still being formed; clears the
//              engine, which then runs SW shifts once go drops
//   bin      : binary operand, must stay stable while shifting
//   bcd      : result of the shift taking place this cycle; it is the final
//              conversion in the cycle fin is high
//   fin      : high during the last shift cycle
module bin2bcd_seq
  import acumulador_pkg::*;
#(
  parameter  int SW = 6,
  localparam int DI = bcd_digits(SW),
  localparam int CW = clog2(SW + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [SW-1:0]   bin,
  output logic [4*DI-1:0] bcd,
  output logic            fin
);

  logic [4*DI-1:0] work;
  logic [4*DI-1:0] adj;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   src;
  logic [CW-1:0]   cnt;
  logic            run;

  // The first shift reads bin directly, so the operand can be finalised on
  // the very edge that drops go without costing a load cycle.
  always_comb begin
    src = (cnt == '0) ? bin : sr;
    run = !go && (cnt != CW'(SW));
    fin = run && (cnt == CW'(SW - 1));
    for (int unsigned i = 0; i < DI; i++) adj[4*i +: 4] = add3(work[4*i +: 4]);
    bcd = (4*DI)'({adj, src[SW-1]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      sr   <= '0;
      cnt  <= CW'(SW);
    end else if (go) begin
      work <= '0;
      sr   <= '0;
      cnt  <= '0;
    end else if (run) begin
      work <= bcd;
      sr   <= {src[SW-2:0], 1'b0};
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/acumulador_bcd.sv
// Multi-operand accumulator with sequential binary-to-BCD output.
//   clk, rst : clock, synchronous active-high reset
//   entrada  : operand data bus (W bits), written to reg[sel] on load
//   load     : operand write strobe (IDLE only, ignored when sel >= N)
//   sel      : operand register index
//   start    : begin sum-and-convert (IDLE only)
//   busy     : high in every state but IDLE
//   done     : one-cycle pulse, saida/ovf valid in the same cycle
//   saida    : packed BCD result, digit 0 in [3:0], saturates to all 9s
//   ovf      : sum exceeded 10^DIGITS - 1
module acumulador_bcd
  import acumulador_pkg::*;
#(
  parameter  int W      = 4,
  parameter  int N      = 3,
  parameter  int DIGITS = 2,
  localparam int SW     = W + clog2(N),
  localparam int SELW   = (clog2(N) > 1) ? clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        entrada,
  input  logic                load,
  input  logic [SELW-1:0]     sel,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] saida,
  output logic                ovf
);

  localparam int DI = bcd_digits(SW);

  state_t              state, next;
  logic [W-1:0]        regs [N];
  logic [SW-1:0]       acc;
  logic [SELW-1:0]     idx;
  logic [4*DI-1:0]     bcd;
  logic                fin;
  logic [4*DIGITS-1:0] low_digits;
  logic                high_digits;

  bin2bcd_seq #(.SW(SW)) conv (
    .clk (clk),
    .rst (rst),
    .go  (state == SUM),
    .bin (acc),
    .bcd (bcd),
    .fin (fin)
  );

  // Conversion is exact, so "sum >= 10^DIGITS" is the same as any digit
  // above the displayed ones being non-zero.
  if (DI > DIGITS) begin : g_trunc
    assign low_digits  = bcd[4*DIGITS-1:0];
    assign high_digits = |bcd[4*DI-1:4*DIGITS];
  end else begin : g_fit
    assign low_digits  = (4*DIGITS)'(bcd);
    assign high_digits = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (start) next = SUM;
      SUM:     if (32'(idx) == 32'(N - 1)) next = CONV;
      CONV:    if (fin) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // saida/ovf are written on the edge entering DONE (using the converter's
  // final in-flight shift) so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) regs[i] <= '0;
      acc   <= '0;
      idx   <= '0;
      saida <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load && (32'(sel) < 32'(N))) regs[sel] <= entrada;
          if (start) begin
            acc <= '0;
            idx <= '0;
          end
        end
        SUM: begin
          acc <= acc + SW'(regs[idx]);
          idx <= idx + SELW'(1);
        end
        CONV: begin
          if (fin) begin
            if (high_digits) begin
              saida <= {DIGITS{4'h9}};
              ovf   <= 1'b1;
            end else begin
              saida <= low_digits;
              ovf   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_bcd.sv
// Bench for acumulador_bcd: a default instance (W=4,N=3,DIGITS=2) and a wide
// instance (W=8,N=4,DIGITS=3) share one stimulus stream. A latency/sum model
// predicts busy, done, saida and ovf for each instance every cycle.
module tb_acumulador_bcd;

  logic        clk = 1'b0;
  logic        rst, load, start;
  logic [7:0]  entrada;
  logic [1:0]  sel;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [7:0]  saida0;
  logic [11:0] saida1;

  always #5 clk = ~clk;

  acumulador_bcd dut0 (
    .clk(clk), .rst(rst), .entrada(entrada[3:0]), .load(load), .sel(sel),
    .start(start), .busy(busy0), .done(done0), .saida(saida0), .ovf(ovf0)
  );

  acumulador_bcd #(.W(8), .N(4), .DIGITS(3)) dut1 (
    .clk(clk), .rst(rst), .entrada(entrada), .load(load), .sel(sel),
    .start(start), .busy(busy1), .done(done1), .saida(saida1), .ovf(ovf1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int n_of(input int i);    return i ? 4 : 3;     endfunction
  function automatic int lat_of(input int i);  return i ? 15 : 10;   endfunction // N+SW+1
  function automatic int dig_of(input int i);  return i ? 3 : 2;     endfunction
  function automatic int unsigned mask_of(input int i); return i ? 255 : 15; endfunction

  function automatic logic [31:0] ref_bcd(input int unsigned v, input int d, output bit o);
    int unsigned lim;
    logic [31:0] r;
    lim = 1;
    r = '0;
    for (int k = 0; k < d; k++) lim *= 10;
    o = (v >= lim);
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = o ? 4'd9 : 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  int unsigned ops [2][4];
  int unsigned pend_sum [2];
  int          cnt [2] = '{0, 0};         // cycles of busy remaining, 1 = done cycle
  logic [31:0] exp_saida [2] = '{0, 0};
  bit          exp_ovf [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) ops[i][k] = 0;
        cnt[i] = 0;
        exp_saida[i] = 0;
        exp_ovf[i] = 0;
      end else if (cnt[i] == 0) begin
        if (load && int'(sel) < n_of(i)) ops[i][sel] = entrada & mask_of(i);
        if (start) begin
          pend_sum[i] = 0;
          for (int k = 0; k < n_of(i); k++) pend_sum[i] += ops[i][k];
          cnt[i] = lat_of(i);
        end
      end else begin
        cnt[i]--;
        if (cnt[i] == 1) exp_saida[i] = ref_bcd(pend_sum[i], dig_of(i), exp_ovf[i]);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("busy0", busy0, cnt[0] != 0);
      chk("done0", done0, cnt[0] == 1);
      chk("saida0", saida0, exp_saida[0]);
      chk("ovf0", ovf0, exp_ovf[0]);
      chk("busy1", busy1, cnt[1] != 0);
      chk("done1", done1, cnt[1] == 1);
      chk("saida1", saida1, exp_saida[1]);
      chk("ovf1", ovf1, exp_ovf[1]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic load_op(input logic [1:0] s, input logic [7:0] v);
    load = 1; sel = s; entrada = v;
    @(negedge clk);
    load = 0;
  endtask

  task automatic load_all(input logic [7:0] a, b, c, d);
    load_op(2'd0, a); load_op(2'd1, b); load_op(2'd2, c); load_op(2'd3, d);
  endtask

  // Pulses start (with whatever load is already set up), optionally disturbs
  // the running sequence with start+load, then checks result and latency.
  task automatic run(input logic [7:0] e0, input logic [11:0] e1, input bit o1, input bit disturb);
    int t0, t1;
    t0 = -1;
    t1 = -1;
    start = 1;
    @(negedge clk);
    start = 0;
    load = 0;
    for (int n = 1; n <= 20; n++) begin
      if (disturb && n == 4) begin start = 1; load = 1; sel = 0; entrada = 8'd1; end
      if (n == 5) begin start = 0; load = 0; end
      if (done0 && t0 < 0) begin t0 = n; chk("lit_saida0", saida0, e0); chk("lit_ovf0", ovf0, 0); end
      if (done1 && t1 < 0) begin t1 = n; chk("lit_saida1", saida1, e1); chk("lit_ovf1", ovf1, o1); end
      @(negedge clk);
    end
    chk("lat0", t0, 10);
    chk("lat1", t1, 15);
  endtask

  initial begin
    rst = 1; load = 0; start = 0; sel = 0; entrada = 0;
    repeat (2) @(negedge clk);
    checking = 1;
    chk("rst_saida0", saida0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_ovf1", ovf1, 0);
    rst = 0;
    @(negedge clk);

    load_all(8'd9, 8'd7, 8'd5, 8'd0);
    run(8'h21, 12'h021, 0, 0);
    load_all(8'd255, 8'd255, 8'd255, 8'd255);      // dut0 sees 15s
    run(8'h45, 12'h999, 1, 0);
    load_all(8'd0, 8'd0, 8'd0, 8'd0);
    run(8'h00, 12'h000, 0, 0);
    load_op(2'd0, 8'd200);                         // dut0 sees 8
    run(8'h08, 12'h200, 0, 0);

    // Activity during a sequence must not disturb it or the operands.
    load_all(8'd9, 8'd7, 8'd5, 8'd0);
    run(8'h21, 12'h021, 0, 1);
    run(8'h21, 12'h021, 0, 0);
    load_op(2'd3, 8'd10);                          // out of range for dut0
    run(8'h21, 12'h031, 0, 0);

    // Reset in the 3rd CONV cycle of dut0 aborts both sequences.
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_busy0", busy0, 0);
    chk("abort_saida0", saida0, 0);
    chk("abort_ovf0", ovf0, 0);
    for (int n = 0; n < 12; n++) begin
      chk("abort_nodone0", done0, 0);
      @(negedge clk);
    end
    load_op(2'd0, 8'd1); load_op(2'd1, 8'd2); load_op(2'd2, 8'd3);
    run(8'h06, 12'h006, 0, 0);

    // Load and start in the same cycle.
    load_op(2'd1, 8'd0); load_op(2'd2, 8'd0); load_op(2'd3, 8'd0);
    load = 1; sel = 0; entrada = 8'd4;
    run(8'h04, 12'h004, 0, 0);

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      load    = $urandom_range(0, 1);
      sel     = 2'($urandom_range(0, 3));
      entrada = 8'($urandom);
      start   = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    rst = 0; load = 0; start = 0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acumulador_bcd.md
# acumulador_bcd

Parametrised multi-operand accumulator with sequential binary-to-BCD conversion. It holds N operand registers that are loaded from a shared input bus. On `start` it sums them one per cycle, converts the binary sum to packed BCD digits with a shift-add-3 (double-dabble) engine, and presents the registered result to the display path with a `done` pulse. It generalises the fixed three-operand, 4-bit sum-and-convert datapath to any operand width, operand count and digit count, and adds handshaking and overflow detection.

## Interface
Parameters:
- `W`, 4: operand width in bits.
- `N`, 3: number of operand registers, ≥ 2.
- `DIGITS`, 2: number of BCD output digits.
- Derived: `SW = W + $clog2(N)` is the sum width; `SELW = max(1, $clog2(N))`.

Ports (one clock; reset is synchronous and active-high):
- `clk` — input, 1 — rising-edge clock.
- `rst` — input, 1 — synchronous, active-high reset.
- `entrada` — input, W — shared operand data bus.
- `load` — input, 1 — writes `entrada` into operand register `sel`.
- `sel` — input, SELW — operand register index.
- `start` — input, 1 — begins a sum-and-convert sequence.
- `busy` — output, 1 — high in every state except IDLE.
- `done` — output, 1 — one-cycle pulse when `saida` is updated.
- `saida` — output, 4*DIGITS — packed BCD result, least significant digit in [3:0].
- `ovf` — output, 1 — the sum exceeds 10^DIGITS − 1.

## Operation
- States and transitions:
  - IDLE → SUM on `start`.
  - SUM → CONV after N cycles.
  - CONV → DONE after SW cycles.
  - DONE → IDLE after 1 cycle.
- IDLE:
  - `load` writes `reg[sel]` when `sel < N`; otherwise the write is ignored.
  - `start` clears the accumulator and the index, then enters SUM.
  - If `load` and `start` are high together, the load takes effect and the new value is summed.
- SUM: `acc <= acc + reg[idx]` and `idx <= idx + 1` each cycle. `acc` is SW bits wide, so no internal overflow is possible.
- CONV: standard double-dabble on the SW-bit `acc`, one shift per cycle.
  - Before each shift, add 3 to every BCD nibble that is ≥ 5.
  - The working BCD register is `4*DIGITS_INT` wide, where `DIGITS_INT` is just enough for 2^SW − 1, so the conversion itself never truncates.
- DONE:
  - If the binary sum is ≥ 10^DIGITS: `saida <=` all nibbles 9 and `ovf <= 1`.
  - Otherwise: `saida <=` the low DIGITS BCD digits and `ovf <= 0`.
  - `done = 1` for this cycle only.
- Busy rules: `load` and `start` are ignored while `busy = 1`. Operand registers never change during a sequence.
- Output hold: `saida` and `ovf` keep their values until the next DONE or reset.
- Reset, including mid-sequence:
  - All operand registers, `acc`, `saida` and `ovf` go to 0.
  - `done` and `busy` go to 0, and the state goes to IDLE on the next edge.
  - Any sequence in progress is aborted without a `done` pulse.

## Timing
- With `start` sampled at edge k:
  - SUM occupies cycles k+1 … k+N.
  - CONV occupies cycles k+N+1 … k+N+SW.
  - DONE occurs in cycle k+N+SW+1.
- Total latency from `start` to `done` is N+SW+1 cycles. For the defaults (W=4, N=3, SW=6) it is 10 cycles.
- `saida` and `ovf` are valid in the same cycle that `done` = 1.
- `busy` rises in the cycle after `start` and falls in the cycle after DONE.
- A new `start` is accepted in the first IDLE cycle after DONE, so back-to-back sequences have a period of N+SW+2 cycles.
- `load` has one-cycle write latency: a value loaded at edge k is readable from k+1.

## Structure
- Shared package `acumulador_pkg` contains:
  - the state enum (IDLE, SUM, CONV, DONE);
  - a `clog2` helper;
  - a function computing `DIGITS_INT` from SW;
  - a BCD nibble add-3 function.
- Sub-module `bin2bcd_seq`:
  - parameter SW;
  - ports `clk`, `rst`, `go`, `bin[SW-1:0]`, `bcd`, `fin`;
  - implements the CONV phase.
- The top level keeps the operand register file, the accumulator, the FSM and the overflow/saturation logic.

## Test plan
- Defaults: load 9, 7, 5 into `sel` 0–2, then `start` → `done` at start+10, `saida = 8'h21`, `ovf = 0`, `busy` high for 10 cycles.
- Defaults: all operands 15 → `saida = 8'h45`. All operands 0 → `saida = 8'h00`. `done` is exactly one cycle wide in both cases.
- W=8, N=4, DIGITS=3, all operands 255 (sum 1020) → `ovf = 1`, `saida = 12'h999`, latency 4+10+1 = 15 cycles. Repeat with operands 200, 0, 0, 0 → `saida = 12'h200`, `ovf = 0`.
- Defaults: `start` and `load` pulsed in the middle of a sequence → result unchanged (`8'h21`) and the operand registers are unaltered. `load` with `sel = 3` → ignored.
- Defaults: `rst` asserted in the 3rd CONV cycle → next cycle `busy = 0`, `saida = 0`, `ovf = 0`, no `done`. After reloading 1, 2, 3 and pulsing `start` → `saida = 8'h06`.
- Defaults: `load` and `start` in the same cycle (`sel = 0`, `entrada = 4`, other operands 0) → `saida = 8'h04`.
